// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared Q10.10 constants and FSM state encoding for the fx operator family
package fx_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 10;
  localparam int EXP_W  = 3;

  localparam logic [DATA_W-1:0] ONE     = 20'h00400;
  localparam logic [DATA_W-1:0] SAT_MAX = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fx_state_e;

endpackage

// File: rtl/fx_power_if.sv
// rtl/fx_power_if.sv - request/result pulse bus of the fx_power operator
interface fx_power_if;
  import fx_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data_1;
  logic [EXP_W-1:0]  in_data_2;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_data_1, in_data_2,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data_1, in_data_2,
    output out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/fx_mul_sat.sv
// rtl/fx_mul_sat.sv - combinational Q10.10 multiply, shift and saturate; FX_POWER_ROUND_EN selects round-half-up
module fx_mul_sat
  import fx_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              sat_o
);

  localparam int PW = 2 * DATA_W;
  localparam int QW = PW - FRAC_W;

`ifdef FX_POWER_ROUND_EN
  localparam logic [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  logic [PW-1:0] a_w;
  logic [PW-1:0] b_w;
  logic [QW-1:0] q;

  assign a_w = {{DATA_W{1'b0}}, a_i};
  assign b_w = {{DATA_W{1'b0}}, b_i};

  // The full product cannot reach 2^PW even after rounding, so dropping the
  // top FRAC_W bits of the shifted value loses nothing.
  assign q     = QW'((a_w * b_w + RND) >> FRAC_W);
  assign sat_o = |q[QW-1:DATA_W];
  assign y_o   = sat_o ? SAT_MAX : q[DATA_W-1:0];

endmodule

// File: rtl/fx_power.sv
// rtl/fx_power.sv - iterative Q10.10 base^k unit, one multiply per cycle (rounding via FX_POWER_ROUND_EN)
module fx_power
  import fx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  fx_power_if.slave   bus
);

  fx_state_e         state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic [DATA_W-1:0] mul_y;
  logic              mul_sat;

  fx_mul_sat u_mul (
    .a_i   (acc_q),
    .b_i   (base_q),
    .y_o   (mul_y),
    .sat_o (mul_sat)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          base_d  = bus.in_data_1;
          exp_d   = bus.in_data_2;
          acc_d   = ONE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.in_data_2 == '0) ? DONE : MUL;
        end
      end
      MUL: begin
        // Saturation is sticky: once clipped, later multiplies cannot recover.
        if (mul_sat || ovf_q) begin
          acc_d = SAT_MAX;
          ovf_d = 1'b1;
        end else begin
          acc_d = mul_y;
        end
        cnt_d = cnt_q + EXP_W'(1);
        if (cnt_q == exp_q - EXP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        out_data_d  = acc_q;
        out_ovf_d   = ovf_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
